// File: rtl/prio_grant_fsm_pkg.sv
// Shared types and constants for the priority-code grant FSM.
package prio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_e;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_C    = 2'b01;
  localparam logic [1:0] CODE_B    = 2'b10;
  localparam logic [1:0] CODE_A    = 2'b11;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_A    = 3'b100;
  localparam logic [2:0] GNT_B    = 3'b010;
  localparam logic [2:0] GNT_C    = 3'b001;

  function automatic logic [2:0] decode_code(input logic [1:0] code);
    logic [2:0] gnt;
    case (code)
      CODE_A:  gnt = GNT_A;
      CODE_B:  gnt = GNT_B;
      CODE_C:  gnt = GNT_C;
      default: gnt = GNT_NONE;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/prio_grant_fsm_if.sv
// Request/grant bundle between the encoder-side master and the grant FSM.
interface prio_grant_fsm_if #(
  parameter int CNT_W = 8
);

  logic [1:0]       code;
  logic             done;
  logic [2:0]       grant;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] total_grants;

  modport master (
    output code,
    output done,
    input  grant,
    input  busy,
    input  timeout,
    input  total_grants
  );

  modport slave (
    input  code,
    input  done,
    output grant,
    output busy,
    output timeout,
    output total_grants
  );

endinterface

// File: rtl/prio_grant_fsm_sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prio_grant_fsm.sv
// Latches one nonzero priority code into a registered one-hot grant, holds it
// until done or hold expiry, then forces a single-cycle release gap.
module prio_grant_fsm
  import prio_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  prio_grant_fsm_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             req_s;
  logic             expire_s;
  logic             grant_inc_s;
  logic [CNT_W-1:0] total_s;

  assign req_s       = (bus.code != CODE_NONE);
  assign expire_s    = (hold_q == HOLD_LAST);
  assign grant_inc_s = (state_q == IDLE) && req_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= {HOLD_W{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = {HOLD_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (bus.done || expire_s) begin
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
          hold_d  = hold_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done takes precedence over expiry, so a tie never raises timeout.
  always_comb begin
    grant_d   = GNT_NONE;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          grant_d = decode_code(bus.code);
        end else begin
          grant_d = GNT_NONE;
        end
      end
      GRANT: begin
        if (bus.done) begin
          grant_d = GNT_NONE;
        end else if (expire_s) begin
          timeout_d = 1'b1;
        end else begin
          grant_d = grant_q;
        end
      end
      default: grant_d = GNT_NONE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= GNT_NONE;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_total_grants (
    .clk  (clk),
    .rst  (rst),
    .inc  (grant_inc_s),
    .count(total_s)
  );

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.timeout      = timeout_q;
  assign bus.total_grants = total_s;

endmodule
